// File: rtl/master_port_burst.sv
// master_port_burst: serial-bus master port. A device request of 1..2^LEN_WIDTH
// beats becomes back-to-back serial transactions to consecutive slave memory
// addresses, with the bus request held for the whole burst, a programmable ack
// timeout and error reporting on abort.
module master_port_burst #(
    parameter int ADDR_WIDTH           = 16,
    parameter int DATA_WIDTH           = 8,
    parameter int SLAVE_MEM_ADDR_WIDTH = 12,
    parameter int LEN_WIDTH            = 4,
    parameter int TIMEOUT              = 5
) (
    input  logic                  clk,
    input  logic                  rstn,
    // device side
    input  logic [ADDR_WIDTH-1:0] daddr,
    input  logic                  dmode,
    input  logic [LEN_WIDTH-1:0]  dlen,
    input  logic                  dvalid,
    output logic                  dready,
    input  logic [DATA_WIDTH-1:0] dwdata,
    output logic                  dwreq,
    output logic [DATA_WIDTH-1:0] drdata,
    output logic                  drvalid,
    output logic                  ddone,
    output logic                  derr,
    // bus side
    output logic                  mwdata,
    output logic                  mvalid,
    output logic                  mmode,
    input  logic                  mrdata,
    input  logic                  svalid,
    output logic                  mbreq,
    input  logic                  mbgrant,
    input  logic                  msplit,
    input  logic                  ack
);

    localparam int DEV_W = ADDR_WIDTH - SLAVE_MEM_ADDR_WIDTH;
    localparam int MEM_W = SLAVE_MEM_ADDR_WIDTH;
    // One shift register serves device address, memory address and write data,
    // so it is as wide as the widest of the three.
    localparam int SH_W  = (DEV_W > MEM_W) ? ((DEV_W > DATA_WIDTH) ? DEV_W : DATA_WIDTH)
                                           : ((MEM_W > DATA_WIDTH) ? MEM_W : DATA_WIDTH);
    localparam int CNT_W = $clog2(SH_W + 1);
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    localparam logic [CNT_W-1:0] DEV_LAST  = CNT_W'(DEV_W - 1);
    localparam logic [CNT_W-1:0] MEM_LAST  = CNT_W'(MEM_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_REQ,
        S_SADDR,
        S_WAIT,
        S_ADDR,
        S_WSETUP,
        S_WDATA,
        S_RDATA,
        S_SPLIT,
        S_NEXT
    } state_t;

    state_t                  state_reg,    state_next;
    logic [CNT_W-1:0]        cnt_reg,      cnt_next;
    logic [TO_W-1:0]         tcnt_reg,     tcnt_next;
    logic [SH_W-1:0]         sh_reg,       sh_next;
    logic [DEV_W-1:0]        dev_addr_reg, dev_addr_next;
    logic [MEM_W-1:0]        mem_addr_reg, mem_addr_next;
    logic                    mode_reg,     mode_next;
    logic [LEN_WIDTH-1:0]    len_reg,      len_next;
    logic [LEN_WIDTH-1:0]    beat_reg,     beat_next;
    logic [DATA_WIDTH-1:0]   wdata_reg,    wdata_next;
    logic [DATA_WIDTH-1:0]   rdata_reg,    rdata_next;
    logic [DATA_WIDTH-1:0]   drdata_reg,   drdata_next;
    logic                    derr_reg,     derr_next;
    logic                    abort;

    // One-hot decode of the read bit index; the captured word is the partial
    // word with only the addressed bit replaced by mrdata.
    logic [DATA_WIDTH-1:0]   bit_sel;
    logic [DATA_WIDTH-1:0]   rdata_cap;

    generate
        for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_bit_sel
            assign bit_sel[gi] = (cnt_reg == CNT_W'(gi));
        end
    endgenerate

    assign rdata_cap = (rdata_reg & ~bit_sel) | (bit_sel & {DATA_WIDTH{mrdata}});

    // State and datapath registers; asynchronous reset clears everything.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg    <= S_IDLE;
            cnt_reg      <= '0;
            tcnt_reg     <= '0;
            sh_reg       <= '0;
            dev_addr_reg <= '0;
            mem_addr_reg <= '0;
            mode_reg     <= 1'b0;
            len_reg      <= '0;
            beat_reg     <= '0;
            wdata_reg    <= '0;
            rdata_reg    <= '0;
            drdata_reg   <= '0;
            derr_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            tcnt_reg     <= tcnt_next;
            sh_reg       <= sh_next;
            dev_addr_reg <= dev_addr_next;
            mem_addr_reg <= mem_addr_next;
            mode_reg     <= mode_next;
            len_reg      <= len_next;
            beat_reg     <= beat_next;
            wdata_reg    <= wdata_next;
            rdata_reg    <= rdata_next;
            drdata_reg   <= drdata_next;
            derr_reg     <= derr_next;
        end
    end

    // Next-state, datapath updates and strobes for the burst sequencer.
    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        tcnt_next     = tcnt_reg;
        sh_next       = sh_reg;
        dev_addr_next = dev_addr_reg;
        mem_addr_next = mem_addr_reg;
        mode_next     = mode_reg;
        len_next      = len_reg;
        beat_next     = beat_reg;
        wdata_next    = wdata_reg;
        rdata_next    = rdata_reg;
        drdata_next   = drdata_reg;
        derr_next     = derr_reg;
        dready        = 1'b0;
        dwreq         = 1'b0;
        drvalid       = 1'b0;
        ddone         = 1'b0;
        mwdata        = 1'b0;
        mvalid        = 1'b0;
        abort         = 1'b0;

        case (state_reg)
            S_IDLE: begin
                dready = 1'b1;
                if (dvalid) begin
                    dev_addr_next = daddr[ADDR_WIDTH-1:MEM_W];
                    mem_addr_next = daddr[MEM_W-1:0];
                    mode_next     = dmode;
                    len_next      = dlen;
                    wdata_next    = dwdata;
                    beat_next     = '0;
                    derr_next     = 1'b0;
                    state_next    = S_REQ;
                end
            end

            S_REQ: begin
                if (mbgrant) begin
                    cnt_next   = '0;
                    sh_next    = SH_W'(dev_addr_reg);
                    state_next = S_SADDR;
                end
            end

            S_SADDR: begin
                mvalid  = 1'b1;
                mwdata  = sh_reg[0];
                sh_next = sh_reg >> 1;
                if (cnt_reg == DEV_LAST) begin
                    cnt_next   = '0;
                    tcnt_next  = '0;
                    state_next = S_WAIT;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end

            // ack on the final counted cycle still wins over the abort.
            S_WAIT: begin
                if (ack) begin
                    cnt_next   = '0;
                    sh_next    = SH_W'(mem_addr_reg);
                    state_next = S_ADDR;
                end else if (tcnt_reg == TO_LAST) begin
                    abort      = 1'b1;
                    ddone      = 1'b1;
                    derr_next  = 1'b1;
                    state_next = S_IDLE;
                end else begin
                    tcnt_next = tcnt_reg + TO_W'(1);
                end
            end

            S_ADDR: begin
                mvalid  = 1'b1;
                mwdata  = sh_reg[0];
                sh_next = sh_reg >> 1;
                if (cnt_reg == MEM_LAST) begin
                    cnt_next = '0;
                    if (mode_reg) begin
                        sh_next    = SH_W'(wdata_reg);
                        state_next = S_WSETUP;
                    end else begin
                        state_next = S_RDATA;
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end

            S_WSETUP: begin
                state_next = S_WDATA;
            end

            S_WDATA: begin
                mvalid  = 1'b1;
                mwdata  = sh_reg[0];
                sh_next = sh_reg >> 1;
                if (cnt_reg == DATA_LAST) begin
                    cnt_next   = '0;
                    state_next = S_NEXT;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end

            // A split in the same cycle as svalid wins; that bit is re-sent later.
            S_RDATA: begin
                if (msplit) begin
                    state_next = S_SPLIT;
                end else if (svalid) begin
                    rdata_next = rdata_cap;
                    if (cnt_reg == DATA_LAST) begin
                        drdata_next = rdata_cap;
                        cnt_next    = '0;
                        state_next  = S_NEXT;
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
            end

            // cnt_reg is left untouched so the read resumes at the same bit.
            S_SPLIT: begin
                if (!msplit && mbgrant) begin
                    state_next = S_RDATA;
                end
            end

            S_NEXT: begin
                drvalid = !mode_reg;
                if (beat_reg == len_reg) begin
                    ddone      = 1'b1;
                    state_next = S_IDLE;
                end else begin
                    mem_addr_next = mem_addr_reg + MEM_W'(1);
                    beat_next     = beat_reg + LEN_WIDTH'(1);
                    if (mode_reg) begin
                        dwreq      = 1'b1;
                        wdata_next = dwdata;
                    end
                    cnt_next   = '0;
                    sh_next    = SH_W'(dev_addr_reg);
                    state_next = S_SADDR;
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // The error flag is visible in the abort cycle itself and then held.
    assign derr   = derr_reg | abort;
    assign drdata = drdata_reg;
    assign mmode  = mode_reg;
    assign mbreq  = (state_reg != S_IDLE);

endmodule

// File: tb/tb_master_port_burst.sv
// tb_master_port_burst: directed bursts against master_port_burst. Stimulus
// pushes the expected serial bits, read words and done/err flags into queues;
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_master_port_burst;

    localparam int AW   = 16;
    localparam int DW   = 8;
    localparam int MW   = 12;
    localparam int LW   = 4;
    localparam int TO   = 5;
    localparam int DEVW = AW - MW;
    // SADDR + one WAIT + ADDR + WSETUP + WDATA + NEXT
    localparam int BEAT_CYC = DEVW + 1 + MW + 1 + DW + 1;

    logic          clk;
    logic          rstn;
    logic [AW-1:0] daddr;
    logic          dmode;
    logic [LW-1:0] dlen;
    logic          dvalid;
    logic          dready;
    logic [DW-1:0] dwdata;
    logic          dwreq;
    logic [DW-1:0] drdata;
    logic          drvalid;
    logic          ddone;
    logic          derr;
    logic          mwdata;
    logic          mvalid;
    logic          mmode;
    logic          mrdata;
    logic          svalid;
    logic          mbreq;
    logic          mbgrant;
    logic          msplit;
    logic          ack;

    master_port_burst #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SLAVE_MEM_ADDR_WIDTH(MW),
        .LEN_WIDTH(LW), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rstn(rstn),
        .daddr(daddr), .dmode(dmode), .dlen(dlen), .dvalid(dvalid), .dready(dready),
        .dwdata(dwdata), .dwreq(dwreq), .drdata(drdata), .drvalid(drvalid),
        .ddone(ddone), .derr(derr),
        .mwdata(mwdata), .mvalid(mvalid), .mmode(mmode), .mrdata(mrdata), .svalid(svalid),
        .mbreq(mbreq), .mbgrant(mbgrant), .msplit(msplit), .ack(ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    bit            exp_bits[$];
    logic [DW-1:0] exp_rd[$];
    bit            exp_derr[$];

    logic [DW-1:0] wbuf [16];
    logic [DW-1:0] rbuf [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: DUT output appeared with nothing expected", name);
    endtask

    task automatic push_bits(input logic [DEVW-1:0] dev, input logic [MW-1:0] mem,
                             input bit wr, input logic [DW-1:0] w);
        for (int i = 0; i < DEVW; i++) exp_bits.push_back(dev[i]);
        for (int i = 0; i < MW; i++)   exp_bits.push_back(mem[i]);
        if (wr) for (int i = 0; i < DW; i++) exp_bits.push_back(w[i]);
    endtask

    task automatic check_queues(input string tag);
        check({tag, "_bits_left"}, exp_bits.size(), 0);
        check({tag, "_rd_left"},   exp_rd.size(),   0);
        check({tag, "_done_left"}, exp_derr.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_dready"},  dready,  1);
        check({tag, "_dwreq"},   dwreq,   0);
        check({tag, "_drdata"},  drdata,  0);
        check({tag, "_drvalid"}, drvalid, 0);
        check({tag, "_ddone"},   ddone,   0);
        check({tag, "_derr"},    derr,    0);
        check({tag, "_mwdata"},  mwdata,  0);
        check({tag, "_mvalid"},  mvalid,  0);
        check({tag, "_mmode"},   mmode,   0);
        check({tag, "_mbreq"},   mbreq,   0);
    endtask

    // Monitor: pop and compare on every presented output.
    logic    mbreq_q, ddone_q;
    bit      mon_bit, mon_err;
    logic [DW-1:0] mon_rd;
    always @(negedge clk) begin
        if (!rstn) begin
            mbreq_q <= 1'b0;
            ddone_q <= 1'b0;
        end else begin
            if (mvalid) begin
                if (exp_bits.size() == 0) unexpected("mwdata_extra");
                else begin
                    mon_bit = exp_bits.pop_front();
                    check("mwdata_bit", mwdata, mon_bit);
                end
            end
            if (drvalid) begin
                if (exp_rd.size() == 0) unexpected("drvalid_extra");
                else begin
                    mon_rd = exp_rd.pop_front();
                    check("drdata", drdata, mon_rd);
                end
            end
            if (ddone) begin
                if (exp_derr.size() == 0) unexpected("ddone_extra");
                else begin
                    mon_err = exp_derr.pop_front();
                    check("derr_at_ddone", derr, mon_err);
                    if (!mon_err && !mmode) check("read_ddone_with_drvalid", drvalid, 1);
                end
            end
            if (mbreq_q && !mbreq) check("mbreq_drop_only_after_ddone", ddone_q, 1);
            mbreq_q <= mbreq;
            ddone_q <= ddone;
        end
    end

    task automatic do_write(input logic [AW-1:0] addr, input int len, input bit timeout);
        int cyc, t_first, t_last_v, t_done, nreq, k;
        bit pend, done;
        $display("write addr=0x%h len=%0d ack=%0d", addr, len, !timeout);
        if (timeout) begin
            for (int i = 0; i < DEVW; i++) exp_bits.push_back(addr[MW+i]);
            exp_derr.push_back(1'b1);
        end else begin
            for (int b = 0; b <= len; b++)
                push_bits(addr[AW-1:MW], addr[MW-1:0] + MW'(b), 1'b1, wbuf[b]);
            exp_derr.push_back(1'b0);
        end
        @(negedge clk);
        daddr = addr; dmode = 1'b1; dlen = LW'(len); dwdata = wbuf[0]; dvalid = 1'b1;
        @(negedge clk);
        dvalid = 1'b0; dwdata = wbuf[1];
        check("mmode_write", mmode, 1);
        check("dready_busy", dready, 0);
        k = 1; pend = 0; done = 0; cyc = 0; t_first = -1; t_last_v = 0; t_done = 0; nreq = 0;
        while (!done && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            dvalid = 1'b0;
            if (pend) begin
                if (k < 15) k++;
                dwdata = wbuf[k];
                pend = 0;
            end
            // a stray request mid-burst must be ignored
            if (!timeout && cyc == 12) begin
                dvalid = 1'b1;
                daddr  = '1;
            end
            if (mvalid) begin
                if (t_first < 0) t_first = cyc;
                t_last_v = cyc;
            end
            if (dwreq) begin
                nreq++;
                pend = 1;
            end
            if (ddone) begin
                done   = 1;
                t_done = cyc;
            end
        end
        dvalid = 1'b0;
        check("ddone_seen", done, 1);
        check("dwreq_count", nreq, timeout ? 0 : len);
        if (timeout) check("wait_cycles", t_done - t_last_v, TO);
        else         check("burst_cycles", t_done - t_first + 1, (len + 1) * BEAT_CYC);
        @(negedge clk);
        check("dready_after", dready, 1);
        check("derr_held", derr, timeout);
        check_queues("write");
    endtask

    task automatic do_read(input logic [AW-1:0] addr, input int len, input bit split);
        int cyc, falls;
        bit prev;
        $display("read addr=0x%h len=%0d split=%0d", addr, len, split);
        for (int b = 0; b <= len; b++) begin
            push_bits(addr[AW-1:MW], addr[MW-1:0] + MW'(b), 1'b0, '0);
            exp_rd.push_back(rbuf[b]);
        end
        exp_derr.push_back(1'b0);
        @(negedge clk);
        daddr = addr; dmode = 1'b0; dlen = LW'(len); dvalid = 1'b1;
        @(negedge clk);
        dvalid = 1'b0;
        check("mmode_read", mmode, 0);
        for (int b = 0; b <= len; b++) begin
            // second mvalid fall of a beat marks entry to the read data phase
            falls = 0; prev = 0; cyc = 0;
            while (falls < 2 && cyc < 200) begin
                @(negedge clk);
                cyc++;
                if (prev && !mvalid) falls++;
                prev = mvalid;
            end
            check("rdata_phase_reached", falls, 2);
            for (int i = 0; i < DW; i++) begin
                if (split && i == 3) begin
                    msplit = 1'b1; svalid = 1'b1; mrdata = ~rbuf[b][i];
                    @(negedge clk);
                    msplit = 1'b0; mbgrant = 1'b0; svalid = 1'b0;
                    for (int c = 0; c < 10; c++) begin
                        check("split_mvalid_low", mvalid, 0);
                        check("split_mbreq_high", mbreq, 1);
                        @(negedge clk);
                    end
                    mbgrant = 1'b1;
                    @(negedge clk);
                end
                mrdata = rbuf[b][i]; svalid = 1'b1;
                @(negedge clk);
            end
            svalid = 1'b0; mrdata = 1'b0;
        end
        @(negedge clk);
        check("dready_after_read", dready, 1);
        check_queues("read");
    endtask

    initial begin
        int cyc;
        rstn = 1'b0; daddr = '0; dmode = 1'b0; dlen = '0; dvalid = 1'b0; dwdata = '0;
        mrdata = 1'b0; svalid = 1'b0; mbgrant = 1'b1; msplit = 1'b0; ack = 1'b1;
        for (int i = 0; i < 16; i++) begin wbuf[i] = '0; rbuf[i] = '0; end
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rstn = 1'b1;

        // single write: dev 1 -> 1,0,0,0 ; mem 0x234 ; data 0xA5
        wbuf[0] = 8'hA5;
        do_write(16'h1234, 0, 1'b0);

        // burst across the memory address wrap: 0xFFE,0xFFF,0x000,0x001
        wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33; wbuf[3] = 8'h44;
        do_write(16'h2FFE, 3, 1'b0);

        // two-beat read
        rbuf[0] = 8'h5A; rbuf[1] = 8'hC3;
        do_read(16'h3010, 1, 1'b0);

        // read interrupted by a split after 3 bits
        rbuf[0] = 8'h96;
        do_read(16'h4020, 0, 1'b1);

        // no ack: abort after TIMEOUT wait cycles
        ack = 1'b0;
        wbuf[0] = 8'h77; wbuf[1] = 8'h88; wbuf[2] = 8'h99;
        do_write(16'h7123, 2, 1'b1);
        ack = 1'b1;

        // reset during the second beat's data phase
        $display("write addr=0x5100 len=2 reset mid-burst");
        wbuf[0] = 8'h81; wbuf[1] = 8'h42; wbuf[2] = 8'h24;
        push_bits(4'h5, 12'h100, 1'b1, wbuf[0]);
        push_bits(4'h5, 12'h101, 1'b1, wbuf[1]);
        @(negedge clk);
        daddr = 16'h5100; dmode = 1'b1; dlen = 4'd2; dwdata = wbuf[0]; dvalid = 1'b1;
        @(negedge clk);
        dvalid = 1'b0; dwdata = wbuf[1];
        cyc = 0;
        while (!dwreq && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("reset_test_dwreq_seen", dwreq, 1);
        @(negedge clk);
        dwdata = wbuf[2];
        repeat (20) @(negedge clk);
        check("reset_test_mid_wdata", mvalid, 1);
        #2 rstn = 1'b0;
        #1 check_reset_outputs("async_reset");
        exp_bits.delete();
        exp_rd.delete();
        exp_derr.delete();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (5) @(negedge clk);
        check("post_reset_idle", dready, 1);

        // normal operation after reset
        wbuf[0] = 8'h3C;
        do_write(16'h1FFF, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
